core_bus_arbiter: RTL and testbench

//  Shares one AXI4-Lite master port between the instruction-fetch requester (IF, read-only) and the

---
 rtl/core_bus_arbiter_pkg.sv | 28 ++
 rtl/core_bus_arbiter_rr.sv | 43 ++++
 rtl/core_bus_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_core_bus_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bus_arbiter_pkg.sv
// Shared definitions for the core bus arbiter: FSM state encoding, bus owner
// encoding, AXI response/protection constants and a small ARPROT helper.
package core_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW_W = 3'd3,
        S_B    = 3'd4,
        S_RESP = 3'd5
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [2:0] PROT_INSTR    = 3'b100;
    localparam logic [2:0] PROT_DATA     = 3'b000;

    // Instruction fetches are tagged as instruction accesses on ARPROT[2].
    function automatic logic [2:0] prot_for(input owner_e owner);
        return (owner == OWN_IF) ? PROT_INSTR : PROT_DATA;
    endfunction

endpackage

// File: rtl/core_bus_arbiter_rr.sv
// Two-way request picker with a last-grant register.
// Ports:
//   clk_i, rst_ni  clock / asynchronous active-low reset
//   req_if_i       fetch requester is asking
//   req_d_i        data requester is asking
//   update_i       a transaction has completed; record served_i as last grant
//   served_i       owner of the completed transaction
//   grant_o        winner among the current requests (meaningful when any req is high)
module core_bus_arbiter_rr
    import core_bus_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   req_if_i,
    input  logic   req_d_i,
    input  logic   update_i,
    input  owner_e served_i,
    output owner_e grant_o
);

    owner_e last_gnt_q;

    // Reset value IF makes the first tie after reset go to D.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt_q <= OWN_IF;
        end else if (update_i) begin
            last_gnt_q <= served_i;
        end
    end

    always_comb begin
        grant_o = OWN_D;
        if (req_if_i && !req_d_i) begin
            grant_o = OWN_IF;
        end else if (req_if_i && req_d_i && (ROUND_ROBIN != 0) && (last_gnt_q == OWN_D)) begin
            grant_o = OWN_IF;
        end
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// Shares one AXI4-Lite master port between the instruction fetch requester
// (read-only) and the data load/store requester. One transaction at a time;
// completion is signalled by a registered one-cycle DONE pulse to the owner.
// Ports:
//   clk_i, rst_ni                       clock / asynchronous active-low reset
//   if_req_i, if_addr_i                 fetch request and address
//   if_rdata_o, if_done_o, if_err_o     fetch result, completion pulse, error flag
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i, d_strb_i                 load/store request
//   d_rdata_o, d_done_o, d_err_o        load result, completion pulse, error flag
//   m_ar*/m_r*/m_aw*/m_w*/m_b*          AXI4-Lite master channels
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_done_o,
    output logic                if_err_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_strb_i,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_done_o,
    output logic                d_err_o,
    output logic [ADDR_W-1:0]   m_araddr_o,
    output logic [2:0]          m_arprot_o,
    output logic                m_arvalid_o,
    input  logic                m_arready_i,
    input  logic [DATA_W-1:0]   m_rdata_i,
    input  logic [1:0]          m_rresp_i,
    input  logic                m_rvalid_i,
    output logic                m_rready_o,
    output logic [ADDR_W-1:0]   m_awaddr_o,
    output logic                m_awvalid_o,
    input  logic                m_awready_i,
    output logic [DATA_W-1:0]   m_wdata_o,
    output logic [DATA_W/8-1:0] m_wstrb_o,
    output logic                m_wvalid_o,
    input  logic                m_wready_i,
    input  logic [1:0]          m_bresp_i,
    input  logic                m_bvalid_i,
    output logic                m_bready_o
);

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] strb_q, strb_d;
    logic                aw_ok_q, aw_ok_d;
    logic                w_ok_q, w_ok_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_done_q, d_done_q, if_err_q, d_err_q;
    logic                rr_update;
    logic                aw_done, w_done;
    owner_e              grant;

    core_bus_arbiter_rr #(
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_rr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_if_i(if_req_i),
        .req_d_i (d_req_i),
        .update_i(rr_update),
        .served_i(owner_q),
        .grant_o (grant)
    );

    // Bus-side outputs decode straight from registers, so an asynchronous
    // reset drops every VALID/READY immediately.
    assign m_arvalid_o = (state_q == S_AR);
    assign m_rready_o  = (state_q == S_R);
    assign m_awvalid_o = (state_q == S_AW_W) && !aw_ok_q;
    assign m_wvalid_o  = (state_q == S_AW_W) && !w_ok_q;
    assign m_bready_o  = (state_q == S_B);
    assign m_araddr_o  = addr_q;
    assign m_awaddr_o  = addr_q;
    assign m_arprot_o  = prot_for(owner_q);
    assign m_wdata_o   = wdata_q;
    assign m_wstrb_o   = strb_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign if_done_o   = if_done_q;
    assign d_done_o    = d_done_q;
    assign if_err_o    = if_err_q;
    assign d_err_o     = d_err_q;

    // A channel counts as done once it has handshaken, now or earlier.
    assign aw_done = aw_ok_q || (m_awvalid_o && m_awready_i);
    assign w_done  = w_ok_q  || (m_wvalid_o  && m_wready_i);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        aw_ok_d    = aw_ok_q;
        w_ok_d     = w_ok_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        rr_update  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (if_req_i || d_req_i) begin
                    owner_d = grant;
                    err_d   = 1'b0;
                    if (grant == OWN_IF) begin
                        addr_d  = if_addr_i;
                        state_d = S_AR;
                    end else begin
                        addr_d = d_addr_i;
                        if (d_we_i) begin
                            wdata_d = d_wdata_i;
                            strb_d  = d_strb_i;
                            state_d = S_AW_W;
                        end else begin
                            state_d = S_AR;
                        end
                    end
                end
            end
            S_AR: begin
                if (m_arready_i) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (m_rvalid_i) begin
                    err_d = (m_rresp_i != AXI_RESP_OKAY);
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = m_rdata_i;
                    end else begin
                        d_rdata_d = m_rdata_i;
                    end
                    state_d = S_RESP;
                end
            end
            S_AW_W: begin
                if (aw_done && w_done) begin
                    aw_ok_d = 1'b0;
                    w_ok_d  = 1'b0;
                    state_d = S_B;
                end else begin
                    aw_ok_d = aw_done;
                    w_ok_d  = w_done;
                end
            end
            S_B: begin
                if (m_bvalid_i) begin
                    err_d   = (m_bresp_i != AXI_RESP_OKAY);
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rr_update = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_D;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            aw_ok_q    <= 1'b0;
            w_ok_q     <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_err_q   <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            aw_ok_q    <= aw_ok_d;
            w_ok_q     <= w_ok_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            // DONE/ERR are high exactly for the single S_RESP cycle.
            if_done_q  <= (state_d == S_RESP) && (owner_q == OWN_IF);
            d_done_q   <= (state_d == S_RESP) && (owner_q == OWN_D);
            if_err_q   <= (state_d == S_RESP) && (owner_q == OWN_IF) && err_d;
            d_err_q    <= (state_d == S_RESP) && (owner_q == OWN_D) && err_d;
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
module tb_core_bus_arbiter;

    localparam logic [31:0] RKEY = 32'h5A5A_1234;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_strb = '0;

    // Instance 0: ROUND_ROBIN=1, instance 1: ROUND_ROBIN=0
    logic [1:0][31:0] if_rdata_v, d_rdata_v, araddr, rdata, awaddr, wdata, s_aw_addr, s_wdata;
    logic [1:0][3:0]  wstrb, s_wstrb;
    logic [1:0][2:0]  arprot;
    logic [1:0][1:0]  rresp, bresp;
    logic [1:0] if_done_v, if_err_v, d_done_v, d_err_v;
    logic [1:0] arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;

    int          cfg_ar_wait = 0, cfg_aw_wait = 0, cfg_w_wait = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = '0, cfg_bresp = '0;
    logic        rand_mode = 1'b0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic        rvalid_q, bvalid_q, aw_seen_q, w_seen_q, stall_q;
        int          ar_cnt_q, aw_cnt_q, w_cnt_q;
        logic [31:0] ar_addr_q, aw_addr_q, wdata_q;
        logic [3:0]  wstrb_q;
        logic        aw_hs, w_hs;

        core_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(gi == 0 ? 1 : 0)) u_dut (
            .clk_i(clk), .rst_ni(rst_n),
            .if_req_i(if_req), .if_addr_i(if_addr),
            .if_rdata_o(if_rdata_v[gi]), .if_done_o(if_done_v[gi]), .if_err_o(if_err_v[gi]),
            .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_strb_i(d_strb),
            .d_rdata_o(d_rdata_v[gi]), .d_done_o(d_done_v[gi]), .d_err_o(d_err_v[gi]),
            .m_araddr_o(araddr[gi]), .m_arprot_o(arprot[gi]), .m_arvalid_o(arvalid[gi]),
            .m_arready_i(arready[gi]),
            .m_rdata_i(rdata[gi]), .m_rresp_i(rresp[gi]), .m_rvalid_i(rvalid[gi]), .m_rready_o(rready[gi]),
            .m_awaddr_o(awaddr[gi]), .m_awvalid_o(awvalid[gi]), .m_awready_i(awready[gi]),
            .m_wdata_o(wdata[gi]), .m_wstrb_o(wstrb[gi]), .m_wvalid_o(wvalid[gi]), .m_wready_i(wready[gi]),
            .m_bresp_i(bresp[gi]), .m_bvalid_i(bvalid[gi]), .m_bready_o(bready[gi])
        );

        // AXI-Lite slave: programmable wait counts, optional random stalls,
        // address-derived data/response in random mode.
        assign arready[gi]   = arvalid[gi] && (ar_cnt_q >= cfg_ar_wait) && !stall_q;
        assign awready[gi]   = awvalid[gi] && (aw_cnt_q >= cfg_aw_wait) && !stall_q;
        assign wready[gi]    = wvalid[gi]  && (w_cnt_q  >= cfg_w_wait)  && !stall_q;
        assign aw_hs         = awvalid[gi] && awready[gi];
        assign w_hs          = wvalid[gi]  && wready[gi];
        assign rvalid[gi]    = rvalid_q;
        assign bvalid[gi]    = bvalid_q;
        assign rdata[gi]     = rand_mode ? (ar_addr_q ^ RKEY) : cfg_rdata;
        assign rresp[gi]     = rand_mode ? (ar_addr_q[4] ? 2'b10 : 2'b00) : cfg_rresp;
        assign bresp[gi]     = rand_mode ? (aw_addr_q[4] ? 2'b11 : 2'b00) : cfg_bresp;
        assign s_aw_addr[gi] = aw_addr_q;
        assign s_wdata[gi]   = wdata_q;
        assign s_wstrb[gi]   = wstrb_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rvalid_q <= 1'b0; bvalid_q <= 1'b0; aw_seen_q <= 1'b0; w_seen_q <= 1'b0;
                stall_q <= 1'b0; ar_cnt_q <= 0; aw_cnt_q <= 0; w_cnt_q <= 0;
                ar_addr_q <= '0; aw_addr_q <= '0; wdata_q <= '0; wstrb_q <= '0;
            end else begin
                stall_q  <= rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
                ar_cnt_q <= (arvalid[gi] && !arready[gi]) ? ar_cnt_q + 1 : 0;
                aw_cnt_q <= (awvalid[gi] && !awready[gi]) ? aw_cnt_q + 1 : 0;
                w_cnt_q  <= (wvalid[gi]  && !wready[gi])  ? w_cnt_q + 1  : 0;
                if (arvalid[gi] && arready[gi]) begin
                    ar_addr_q <= araddr[gi];
                    rvalid_q  <= 1'b1;
                end else if (rvalid_q && rready[gi]) begin
                    rvalid_q <= 1'b0;
                end
                if (aw_hs) aw_addr_q <= awaddr[gi];
                if (w_hs) begin
                    wdata_q <= wdata[gi];
                    wstrb_q <= wstrb[gi];
                end
                if ((aw_seen_q || aw_hs) && (w_seen_q || w_hs)) begin
                    bvalid_q  <= 1'b1;
                    aw_seen_q <= 1'b0;
                    w_seen_q  <= 1'b0;
                end else begin
                    if (aw_hs) aw_seen_q <= 1'b1;
                    if (w_hs)  w_seen_q  <= 1'b1;
                end
                if (bvalid_q && bready[gi]) bvalid_q <= 1'b0;
            end
        end
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] s_rdata;
        logic [1:0]  s_resp;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [2:0]  exp_prot;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cyc, dones, done_cyc, aw_hi, w_hi, first_b, ar_hi, ar_bad, stall_cyc, n0, n1;
        int          own0[4], own1[4];
        logic        got;
        logic [31:0] last_if, last_d, exp_rd;
        logic        if_act, d_act, busy, cur, last, exp_err, abort;
        int          start, n_done;

        vecs[0] = '{is_d:1'b0, we:1'b0, addr:32'h0000_0100, wdata:32'h0, strb:4'h0,
                    s_rdata:32'hDEAD_BEEF, s_resp:2'b00, exp_rdata:32'hDEAD_BEEF, exp_err:1'b0, exp_prot:3'b100};
        vecs[1] = '{is_d:1'b1, we:1'b0, addr:32'h0000_0040, wdata:32'h0, strb:4'h0,
                    s_rdata:32'h1111_2222, s_resp:2'b10, exp_rdata:32'h1111_2222, exp_err:1'b1, exp_prot:3'b000};
        vecs[2] = '{is_d:1'b1, we:1'b1, addr:32'h0000_2000, wdata:32'h1234_5678, strb:4'b0011,
                    s_rdata:32'h0, s_resp:2'b00, exp_rdata:32'h1111_2222, exp_err:1'b0, exp_prot:3'b000};
        vecs[3] = '{is_d:1'b1, we:1'b1, addr:32'h0000_3004, wdata:32'hCAFE_F00D, strb:4'b1111,
                    s_rdata:32'h0, s_resp:2'b10, exp_rdata:32'h1111_2222, exp_err:1'b1, exp_prot:3'b000};
        vecs[4] = '{is_d:1'b0, we:1'b0, addr:32'h0000_0104, wdata:32'h0, strb:4'h0,
                    s_rdata:32'h0BAD_C0DE, s_resp:2'b11, exp_rdata:32'h0BAD_C0DE, exp_err:1'b1, exp_prot:3'b100};
        vecs[5] = '{is_d:1'b1, we:1'b0, addr:32'h0000_0048, wdata:32'h0, strb:4'h0,
                    s_rdata:32'h55AA_55AA, s_resp:2'b00, exp_rdata:32'h55AA_55AA, exp_err:1'b0, exp_prot:3'b000};

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_handshakes", {27'd0, arvalid[0], rready[0], awvalid[0], wvalid[0], bready[0]}, 32'd0);
        chk("rst_done_err", {28'd0, if_done_v[0], d_done_v[0], if_err_v[0], d_err_v[0]}, 32'd0);
        chk("rst_araddr", araddr[0], 32'd0);
        chk("rst_arprot", {29'd0, arprot[0]}, 32'd0);
        chk("rst_if_rdata", if_rdata_v[0], 32'd0);
        chk("rst_d_rdata", d_rdata_v[0], 32'd0);
        chk("rst_wdata_strb", wdata[0] | {28'd0, wstrb[0]}, 32'd0);

        // ---------------- table-driven single transactions ----------------
        last_if = '0; last_d = '0;
        for (int i = 0; i < 6; i++) begin
            cfg_rdata = vecs[i].s_rdata; cfg_rresp = vecs[i].s_resp; cfg_bresp = vecs[i].s_resp;
            if_req = !vecs[i].is_d; d_req = vecs[i].is_d; d_we = vecs[i].we;
            if_addr = vecs[i].addr; d_addr = vecs[i].addr;
            d_wdata = vecs[i].wdata; d_strb = vecs[i].strb;
            cyc = 0; got = 1'b0;
            while (!got && cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (cyc == 1 && !vecs[i].we) begin
                    chk($sformatf("vec%0d_arvalid", i), {31'd0, arvalid[0]}, 32'd1);
                    chk($sformatf("vec%0d_araddr", i), araddr[0], vecs[i].addr);
                    chk($sformatf("vec%0d_arprot", i), {29'd0, arprot[0]}, {29'd0, vecs[i].exp_prot});
                end
                if (if_done_v[0] || d_done_v[0]) got = 1'b1;
            end
            chk($sformatf("vec%0d_latency", i), cyc, 3);
            chk($sformatf("vec%0d_done", i), {30'd0, if_done_v[0], d_done_v[0]},
                vecs[i].is_d ? 32'd1 : 32'd2);
            chk($sformatf("vec%0d_err", i), {30'd0, if_err_v[0], d_err_v[0]},
                vecs[i].exp_err ? (vecs[i].is_d ? 32'd1 : 32'd2) : 32'd0);
            if (vecs[i].is_d) last_d = vecs[i].exp_rdata; else last_if = vecs[i].exp_rdata;
            chk($sformatf("vec%0d_if_rdata", i), if_rdata_v[0], last_if);
            chk($sformatf("vec%0d_d_rdata", i), d_rdata_v[0], last_d);
            if (vecs[i].we) begin
                chk($sformatf("vec%0d_slave_awaddr", i), s_aw_addr[0], vecs[i].addr);
                chk($sformatf("vec%0d_slave_wdata", i), s_wdata[0], vecs[i].wdata);
                chk($sformatf("vec%0d_slave_wstrb", i), {28'd0, s_wstrb[0]}, {28'd0, vecs[i].strb});
            end
            $display("vec %0d: %s %s addr=0x%h done_cycle=%0d", i, vecs[i].is_d ? "D" : "IF",
                     vecs[i].we ? "store" : "read", vecs[i].addr, cyc);
            if_req = 1'b0; d_req = 1'b0;
            @(negedge clk);
        end

        // ---------------- store: AWREADY two cycles before WREADY ----------------
        cfg_aw_wait = 1; cfg_w_wait = 3; cfg_bresp = 2'b00;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'h1234_5678; d_strb = 4'b0011;
        aw_hi = 0; w_hi = 0; first_b = 0; dones = 0; done_cyc = 0; n0 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (awvalid[0]) aw_hi++;
            if (wvalid[0]) w_hi++;
            if (bready[0] && first_b == 0) first_b = c;
            if (if_done_v[0]) n0++;
            if (d_done_v[0]) begin dones++; done_cyc = c; d_req = 1'b0; end
        end
        chk("split_awvalid_cycles", aw_hi, 2);
        chk("split_wvalid_cycles", w_hi, 4);
        chk("split_first_bready", first_b, 5);
        chk("split_d_done_count", dones, 1);
        chk("split_done_cycle", done_cyc, 6);
        chk("split_if_done_count", n0, 0);
        chk("split_slave_wdata", s_wdata[0], 32'h1234_5678);
        chk("split_slave_wstrb", {28'd0, s_wstrb[0]}, 32'd3);
        $display("split store: aw=%0d w=%0d bready@%0d done@%0d", aw_hi, w_hi, first_b, done_cyc);
        cfg_aw_wait = 0; cfg_w_wait = 0;

        // ---------------- ARREADY low for 5 cycles, D_REQ toggling ----------------
        cfg_ar_wait = 5; cfg_rdata = 32'h0A0B_0C0D; cfg_rresp = 2'b00;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
        ar_hi = 0; ar_bad = 0; stall_cyc = 0; dones = 0; done_cyc = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (arvalid[0]) begin
                ar_hi++;
                if (araddr[0] != 32'h0000_0400) ar_bad++;
                if (!arready[0]) stall_cyc++;
            end
            if (d_done_v[0]) begin
                dones++; done_cyc = c;
                chk("arwait_d_rdata", d_rdata_v[0], 32'h0A0B_0C0D);
            end
            if (dones == 0) begin
                d_req = ~d_req; d_addr = $urandom; d_we = 1'($urandom_range(0, 1));
            end else begin
                d_req = 1'b0; d_we = 1'b0;
            end
        end
        chk("arwait_stall_cycles", stall_cyc, 5);
        chk("arwait_arvalid_cycles", ar_hi, 6);
        chk("arwait_araddr_changes", ar_bad, 0);
        chk("arwait_done_count", dones, 1);
        chk("arwait_done_cycle", done_cyc, 8);
        $display("ar wait: arvalid=%0d stalled=%0d done@%0d", ar_hi, stall_cyc, done_cyc);
        cfg_ar_wait = 0;

        // ---------------- reset asserted during S_B ----------------
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_5000; d_wdata = 32'hA5A5_A5A5; d_strb = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("rstb_bready_before", {31'd0, bready[0]}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstb_bready_async", {31'd0, bready[0]}, 32'd0);
        chk("rstb_dones_async", {30'd0, if_done_v[0], d_done_v[0]}, 32'd0);
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstb_idle_valids", {28'd0, arvalid[0], awvalid[0], wvalid[0], bready[0]}, 32'd0);
        $display("reset in S_B: bus quiet after release");

        // ---------------- tie, 4 back-to-back transactions ----------------
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
        cfg_rdata = 32'h1; cfg_rresp = 2'b00;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 4; k++) begin own0[k] = 2; own1[k] = 2; end
        for (int c = 0; c < 60 && n0 < 4; c++) begin
            @(negedge clk);
            if (n1 < 4 && (if_done_v[1] || d_done_v[1])) begin own1[n1] = d_done_v[1] ? 1 : 0; n1++; end
            if (if_done_v[0] || d_done_v[0]) begin own0[n0] = d_done_v[0] ? 1 : 0; n0++; end
        end
        if_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tie_rr_%0d(1=D)", k), own0[k], (k % 2 == 0) ? 1 : 0);
            chk($sformatf("tie_fixed_%0d(1=D)", k), own1[k], 1);
            $display("tie txn %0d: rr=%s fixed=%s", k, own0[k] == 1 ? "D" : "IF", own1[k] == 1 ? "D" : "IF");
        end
        @(negedge clk);
        @(negedge clk);

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        rand_mode = 1'b1;
        if_act = 1'b0; d_act = 1'b0; busy = 1'b0; cur = 1'b0; last = 1'b0; // last: 0=IF, 1=D
        start = 0; n_done = 0; abort = 1'b0;
        for (int c = 0; c < 5000 && n_done < 150 && !abort; c++) begin
            @(negedge clk);
            if (if_done_v[0] || d_done_v[0]) begin
                chk("rand_done_owner", {30'd0, if_done_v[0], d_done_v[0]},
                    !busy ? 32'd0 : (cur ? 32'd1 : 32'd2));
                if (!cur) begin
                    exp_rd = if_addr ^ RKEY; exp_err = if_addr[4];
                    chk("rand_if_rdata", if_rdata_v[0], exp_rd);
                    chk("rand_if_err", {31'd0, if_err_v[0]}, {31'd0, exp_err});
                end else if (!d_we) begin
                    exp_rd = d_addr ^ RKEY; exp_err = d_addr[4];
                    chk("rand_d_rdata", d_rdata_v[0], exp_rd);
                    chk("rand_d_err", {31'd0, d_err_v[0]}, {31'd0, exp_err});
                end else begin
                    exp_err = d_addr[4];
                    chk("rand_st_err", {31'd0, d_err_v[0]}, {31'd0, exp_err});
                    chk("rand_st_addr", s_aw_addr[0], d_addr);
                    chk("rand_st_data", s_wdata[0], d_wdata);
                    chk("rand_st_strb", {28'd0, s_wstrb[0]}, {28'd0, d_strb});
                end
                $display("rand txn %0d: %s addr=0x%h cycles=%0d", n_done, !cur ? "IF read" :
                         (d_we ? "D store" : "D load"), !cur ? if_addr : d_addr, c - start);
                if (!cur) if_act = 1'b0; else d_act = 1'b0;
                last = cur; busy = 1'b0; n_done++;
                // The arbiter sits in its response cycle now; it returns to idle next cycle.
                start = -1;
            end else if (busy && (c - start) > 80) begin
                chk("rand_timeout", 32'd0, 32'd1);
                abort = 1'b1;
            end
            if (!if_act && $urandom_range(0, 2) == 0) begin
                if_act = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom & 32'hFFFF_FFFC;
                d_wdata = $urandom; d_strb = 4'($urandom_range(0, 15));
            end
            if_req = if_act; d_req = d_act;
            if (start == -1) begin
                start = 0;
            end else if (!busy && (if_act || d_act)) begin
                if (if_act && d_act) cur = !last;
                else cur = d_act;
                busy = 1'b1; start = c;
            end
        end
        chk("rand_completed", n_done, 150);
        if_req = 1'b0; d_req = 1'b0; rand_mode = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
